// File: rtl/pc_control_if.sv
// Bus between the decode/ALU side and the next-PC stage.
// The master drives instruction, operand and flag inputs; the slave returns PC state.
interface pc_control_if;
    logic [15:0] instr;
    logic [15:0] rs_data;
    logic        stall;
    logic        z_in;
    logic        n_in;
    logic        v_in;
    logic        z_en;
    logic        n_en;
    logic        v_en;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        branch_taken;
    logic [2:0]  flags;
    logic        hlt;

    modport master (
        output instr, rs_data, stall,
        output z_in, n_in, v_in, z_en, n_en, v_en,
        input  pc_out, pc_plus2, branch_taken, flags, hlt
    );

    modport slave (
        input  instr, rs_data, stall,
        input  z_in, n_in, v_in, z_en, n_en, v_en,
        output pc_out, pc_plus2, branch_taken, flags, hlt
    );
endinterface

// File: rtl/pc_control.sv
// Next-PC stage: owns the PC, the {Z,N,V} flag register and the sticky halt bit.
// Resolves B/BR against the registered flags and redirects with single-cycle latency.
module pc_control #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic         clk,
    input logic         rst,
    pc_control_if.slave bus
);
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [15:0] pc_q, pc_d;
    logic [2:0]  flags_q, flags_d;
    logic        halted_q, halted_d;

    logic [3:0]  opcode;
    logic [2:0]  cond;
    logic        is_b, is_br, is_hlt;
    logic        flag_z, flag_n, flag_v;
    logic        cond_true;
    logic        hlt;
    logic        advance;
    logic        branch_taken;
    logic [15:0] pc_plus2;
    logic [15:0] b_offset;
    logic [15:0] target;

    assign opcode = bus.instr[15:12];
    assign cond   = bus.instr[11:9];
    assign is_b   = (opcode == OP_B);
    assign is_br  = (opcode == OP_BR);
    assign is_hlt = (opcode == OP_HLT);

    assign flag_z = flags_q[2];
    assign flag_n = flags_q[1];
    assign flag_v = flags_q[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            3'b000:  cond_true = ~flag_z;
            3'b001:  cond_true = flag_z;
            3'b010:  cond_true = ~flag_z & ~flag_n;
            3'b011:  cond_true = flag_n;
            3'b100:  cond_true = flag_z | (~flag_z & ~flag_n);
            3'b101:  cond_true = flag_n | flag_z;
            3'b110:  cond_true = flag_v;
            default: cond_true = 1'b1;
        endcase
    end

    assign hlt          = halted_q | is_hlt;
    assign advance      = ~bus.stall & ~hlt;
    assign branch_taken = (is_b | is_br) & cond_true & ~hlt;

    // imm9 is a halfword offset: sign-extend and scale by two.
    assign pc_plus2 = pc_q + 16'd2;
    assign b_offset = {{6{bus.instr[8]}}, bus.instr[8:0], 1'b0};
    assign target   = is_br ? bus.rs_data : (pc_plus2 + b_offset);

    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            pc_d = branch_taken ? target : pc_plus2;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (advance) begin
            if (bus.z_en) flags_d[2] = bus.z_in;
            if (bus.n_en) flags_d[1] = bus.n_in;
            if (bus.v_en) flags_d[0] = bus.v_in;
        end
    end

    assign halted_d = halted_q | (~bus.stall & is_hlt);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            flags_q  <= 3'b000;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            flags_q  <= flags_d;
            halted_q <= halted_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_plus2     = pc_plus2;
    assign bus.branch_taken = branch_taken;
    assign bus.flags        = flags_q;
    assign bus.hlt          = hlt;
endmodule

// File: tb/tb_pc_control.sv
// Directed plus randomized bench for pc_control against an instruction-level
// reference model of PC, flags and halt.
module tb_pc_control;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_control_if bus ();

    pc_control #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errs    = 0;

    logic [15:0] m_pc     = RESET_PC;
    logic [2:0]  m_flags  = 3'b000;
    logic        m_halted = 1'b0;
    logic        obs_bt;
    logic        obs_hlt;

    function automatic logic cond_ok(input logic [2:0] c, input logic [2:0] f);
        logic z, n, v;
        z = f[2]; n = f[1]; v = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one instruction cycle: drive, check combinational view, clock, update model.
    task automatic step(input logic [15:0] ins, input logic [15:0] rsd, input logic st,
                        input logic [2:0] fin, input logic [2:0] fen, input logic r);
        logic [3:0]  op;
        logic        exp_hlt, exp_bt;
        int          off;
        bus.instr   = ins;
        bus.rs_data = rsd;
        bus.stall   = st;
        bus.z_in    = fin[2]; bus.n_in = fin[1]; bus.v_in = fin[0];
        bus.z_en    = fen[2]; bus.n_en = fen[1]; bus.v_en = fen[0];
        rst         = r;
        #1;
        op      = ins[15:12];
        exp_hlt = m_halted || (op == 4'hF);
        exp_bt  = (op == 4'hC || op == 4'hD) && cond_ok(ins[11:9], m_flags) && !exp_hlt;
        vectors++;
        chk("pc_out",       bus.pc_out,   m_pc);
        chk("pc_plus2",     bus.pc_plus2, m_pc + 16'd2);
        chk("branch_taken", {15'b0, bus.branch_taken}, {15'b0, exp_bt});
        chk("hlt",          {15'b0, bus.hlt}, {15'b0, exp_hlt});
        chk("flags",        {13'b0, bus.flags}, {13'b0, m_flags});
        obs_bt  = bus.branch_taken;
        obs_hlt = bus.hlt;
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_flags = 3'b000; m_halted = 1'b0;
        end else begin
            if (!st && !exp_hlt) begin
                if (fen[2]) m_flags[2] = fin[2];
                if (fen[1]) m_flags[1] = fin[1];
                if (fen[0]) m_flags[0] = fin[0];
                if (exp_bt && op == 4'hD) begin
                    m_pc = rsd;
                end else if (exp_bt) begin
                    off = int'(ins[8:0]);
                    if (ins[8]) off = off - 512;
                    m_pc = m_pc + 16'd2 + 16'(off * 2);
                end else begin
                    m_pc = m_pc + 16'd2;
                end
            end
            if (!st && op == 4'hF) m_halted = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] saved_pc;
        logic [2:0]  saved_flags;
        logic [3:0]  op;
        int          sel;

        bus.instr = 16'h0; bus.rs_data = 16'h0; bus.stall = 1'b0;
        bus.z_in = 1'b0; bus.n_in = 1'b0; bus.v_in = 1'b0;
        bus.z_en = 1'b0; bus.n_en = 1'b0; bus.v_en = 1'b0;
        @(negedge clk);

        // Reset and sequential fetch
        step(16'h0000, 16'h0, 1'b0, 3'b000, 3'b000, 1'b1);
        step(16'h0000, 16'h0, 1'b0, 3'b000, 3'b000, 1'b1);
        chk("reset_pc", bus.pc_out, 16'h0000);
        chk("reset_flags", {13'b0, bus.flags}, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            step(16'h0000, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
            chk("seq_pc", bus.pc_out, 16'(2 * i));
        end
        for (int i = 0; i < 3; i++) step(16'h0000, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);

        // B EQ taken then not taken
        step(16'h1000, 16'h0, 1'b0, 3'b100, 3'b100, 1'b0);
        chk("pc_before_beq", bus.pc_out, 16'h0010);
        step(16'hC203, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("beq_taken_bt", {15'b0, obs_bt}, 16'h0001);
        chk("beq_taken_pc", bus.pc_out, 16'h0018);
        step(16'hDE00, 16'h000E, 1'b0, 3'b000, 3'b000, 1'b0);
        step(16'h1000, 16'h0, 1'b0, 3'b000, 3'b100, 1'b0);
        step(16'hC203, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("beq_not_bt", {15'b0, obs_bt}, 16'h0000);
        chk("beq_not_pc", bus.pc_out, 16'h0012);

        // Negative offset and wrap
        step(16'hDE00, 16'h0004, 1'b0, 3'b000, 3'b000, 1'b0);
        step(16'hCFFC, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("neg_off_pc", bus.pc_out, 16'hFFFE);
        step(16'h0000, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("wrap_pc", bus.pc_out, 16'h0000);

        // BR and condition sweep
        step(16'h1000, 16'h0, 1'b0, 3'b010, 3'b110, 1'b0);
        step(16'hD600, 16'h1234, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("br_lt_pc", bus.pc_out, 16'h1234);
        step(16'hD400, 16'h5678, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("br_gt_bt", {15'b0, obs_bt}, 16'h0000);
        chk("br_gt_pc", bus.pc_out, 16'h1236);
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                step(16'h2000, 16'h0, 1'b0, 3'(f), 3'b111, 1'b0);
                step({4'hC, 3'(c), 9'($urandom_range(0, 511))}, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
            end
        end

        // Stall freezes state
        step(16'h1000, 16'h0, 1'b0, 3'b101, 3'b111, 1'b0);
        saved_pc = bus.pc_out; saved_flags = bus.flags;
        for (int i = 0; i < 3; i++) begin
            step(16'hDE00, 16'h4321, 1'b1, 3'($urandom_range(0, 7)), 3'b111, 1'b0);
            chk("stall_pc", bus.pc_out, saved_pc);
            chk("stall_flags", {13'b0, bus.flags}, {13'b0, saved_flags});
        end

        // Halt is sticky until reset
        step(16'hDE00, 16'h0020, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("pc_before_hlt", bus.pc_out, 16'h0020);
        saved_flags = bus.flags;
        step(16'hF000, 16'h0, 1'b0, 3'b010, 3'b111, 1'b0);
        chk("hlt_immediate", {15'b0, obs_hlt}, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            step(16'($urandom), 16'($urandom), 1'b0, 3'($urandom_range(0, 7)), 3'b100, 1'b0);
            chk("halt_pc", bus.pc_out, 16'h0020);
            chk("halt_flags", {13'b0, bus.flags}, {13'b0, saved_flags});
        end
        step(16'h0000, 16'h0, 1'b0, 3'b000, 3'b000, 1'b1);
        chk("halt_reset_pc", bus.pc_out, RESET_PC);
        chk("halt_reset_hlt", {15'b0, bus.hlt}, 16'h0000);

        // Reset beats stall and a taken branch
        step(16'h1000, 16'h0, 1'b0, 3'b111, 3'b111, 1'b0);
        step(16'h0000, 16'h0, 1'b0, 3'b000, 3'b000, 1'b0);
        step(16'hDE00, 16'h4444, 1'b1, 3'b000, 3'b000, 1'b1);
        chk("rst_override_pc", bus.pc_out, RESET_PC);
        chk("rst_override_flags", {13'b0, bus.flags}, 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3)       op = 4'hC;
            else if (sel < 5)  op = 4'hD;
            else if (sel == 5 && $urandom_range(0, 3) == 0) op = 4'hF;
            else               op = 4'($urandom_range(0, 14));
            step({op, 12'($urandom)}, 16'($urandom), ($urandom_range(0, 99) < 20),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
